// File: rtl/shell_slot_arbiter.sv
// Shell slot pool arbiter for two tanks.
// Grants one launch per frame, tracks shell lifetime, kills and per-tank caps.
module shell_slot_arbiter #(
    parameter int NUM_SLOTS    = 4,
    parameter int SLOT_W       = 2,
    parameter int MAX_PER_TANK = 2,
    parameter int LIFETIME     = 300,
    parameter int COOLDOWN     = 15
) (
    input  logic                 frame_clk,
    input  logic                 Reset,
    input  logic [1:0]           fire_req,
    input  logic [NUM_SLOTS-1:0] slot_kill,
    output logic                 launch_valid,
    output logic [SLOT_W-1:0]    launch_slot,
    output logic                 launch_owner,
    output logic [NUM_SLOTS-1:0] slot_active,
    output logic [NUM_SLOTS-1:0] slot_owner,
    output logic [5:0]           tank_count
);

    localparam logic [2:0] MAX_C  = 3'(MAX_PER_TANK);
    localparam logic [9:0] LIFE_C = 10'(LIFETIME);
    localparam logic [7:0] CD_C   = 8'(COOLDOWN);

    logic [9:0]           life [NUM_SLOTS];
    logic [7:0]           cd   [2];
    logic [1:0]           pending;
    logic [1:0]           fire_req_q;
    logic                 rr;

    logic [1:0]           rise;
    logic [2:0]           cnt     [2];
    logic [2:0]           dec     [2];
    logic [2:0]           cnt_nxt [2];
    logic [1:0]           elig;
    logic [1:0]           g_one;
    logic                 grant;
    logic                 gt;
    logic                 contested;
    logic                 any_free;
    logic [SLOT_W-1:0]    free_idx;
    logic [NUM_SLOTS-1:0] retire;

    // Pick the winner, the free slot and the per-tank count updates.
    always_comb begin
        cnt[0]   = tank_count[2:0];
        cnt[1]   = tank_count[5:3];
        rise     = fire_req & ~fire_req_q;
        any_free = |(~slot_active);
        free_idx = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slot_active[i]) begin
                free_idx = SLOT_W'(i);
            end
        end
        for (int t = 0; t < 2; t++) begin
            elig[t] = pending[t] & (cnt[t] < MAX_C) & any_free;
        end
        contested = &elig;
        grant     = |elig;
        gt        = contested ? rr : elig[1];
        g_one[0]  = grant & ~gt;
        g_one[1]  = grant & gt;
        dec[0]    = '0;
        dec[1]    = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            retire[i] = slot_active[i] & (slot_kill[i] | (life[i] == 10'd1));
            if (retire[i]) begin
                dec[slot_owner[i]] = dec[slot_owner[i]] + 3'd1;
            end
        end
        for (int t = 0; t < 2; t++) begin
            cnt_nxt[t] = cnt[t] + {2'b00, g_one[t]} - dec[t];
        end
    end

    // Slot pool, per-tank request/cooldown state and launch strobe.
    always_ff @(posedge frame_clk) begin
        if (Reset) begin
            slot_active  <= '0;
            slot_owner   <= '0;
            pending      <= '0;
            fire_req_q   <= '0;
            tank_count   <= '0;
            launch_valid <= 1'b0;
            launch_slot  <= '0;
            launch_owner <= 1'b0;
            rr           <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) begin
                life[i] <= '0;
            end
            for (int t = 0; t < 2; t++) begin
                cd[t] <= '0;
            end
        end else begin
            fire_req_q   <= fire_req;
            launch_valid <= grant;
            tank_count   <= {cnt_nxt[1], cnt_nxt[0]};
            if (contested) begin
                rr <= ~rr;
            end
            if (grant) begin
                launch_slot  <= free_idx;
                launch_owner <= gt;
            end
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (retire[i]) begin
                    slot_active[i] <= 1'b0;
                    life[i]        <= '0;
                end else if (slot_active[i]) begin
                    life[i] <= life[i] - 10'd1;
                end
            end
            if (grant) begin
                slot_active[free_idx] <= 1'b1;
                slot_owner[free_idx]  <= gt;
                life[free_idx]        <= LIFE_C;
            end
            for (int t = 0; t < 2; t++) begin
                if (g_one[t]) begin
                    cd[t]      <= CD_C;
                    pending[t] <= 1'b0;
                end else begin
                    if (cd[t] != '0) begin
                        cd[t] <= cd[t] - 8'd1;
                    end
                    if (rise[t] && cd[t] == '0 && cnt[t] < MAX_C
                        && !pending[t]) begin
                        pending[t] <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_shell_slot_arbiter.sv
// Randomized scoreboard bench for shell_slot_arbiter.
// Reference model uses timestamps and counted owners instead of counters.
module tb_shell_slot_arbiter;

    localparam int NS   = 4;
    localparam int MAXT = 2;
    localparam int LIFE = 300;
    localparam int CDN  = 15;

    logic          frame_clk = 1'b0;
    logic          Reset = 1'b1;
    logic [1:0]    fire_req = '0;
    logic [NS-1:0] slot_kill = '0;
    logic          launch_valid;
    logic [1:0]    launch_slot;
    logic          launch_owner;
    logic [NS-1:0] slot_active;
    logic [NS-1:0] slot_owner;
    logic [5:0]    tank_count;

    shell_slot_arbiter dut (
        .frame_clk    (frame_clk),
        .Reset        (Reset),
        .fire_req     (fire_req),
        .slot_kill    (slot_kill),
        .launch_valid (launch_valid),
        .launch_slot  (launch_slot),
        .launch_owner (launch_owner),
        .slot_active  (slot_active),
        .slot_owner   (slot_owner),
        .tank_count   (tank_count)
    );

    always #5 frame_clk = ~frame_clk;

    typedef struct {
        int       e;
        bit [3:0] act;
        bit [3:0] own;
        bit [5:0] cnt;
    } st_t;

    typedef struct {
        int e;
        int slot;
        int owner;
    } ln_t;

    st_t sq[$];
    ln_t lq[$];

    int nchk = 0;
    int npass = 0;

    // Model state: shells carry an absolute expiry edge number.
    bit       m_act [NS];
    bit       m_own [NS];
    int       m_exp [NS];
    int       m_lg  [2];
    bit       m_pend[2];
    bit [1:0] m_prev;
    bit       m_rr;
    int       E = 0;

    task automatic chk(string name, int act, int exp);
        nchk++;
        if (act == exp) begin
            npass++;
        end else begin
            $display("FAIL %s at edge %0d: got %0d expected %0d",
                     name, E, act, exp);
        end
    endtask

    task automatic model_step();
        int  cnt[2];
        int  fidx;
        bit  elig[2];
        bit  acc[2];
        bit  gnt;
        int  gt;
        bit  ret[NS];
        st_t s;
        ln_t l;
        if (Reset) begin
            for (int i = 0; i < NS; i++) begin
                m_act[i] = 0;
                m_own[i] = 0;
                m_exp[i] = 0;
            end
            for (int t = 0; t < 2; t++) begin
                m_lg[t]   = -1000;
                m_pend[t] = 0;
            end
            m_prev = 0;
            m_rr   = 0;
        end else begin
            cnt[0] = 0;
            cnt[1] = 0;
            for (int i = 0; i < NS; i++)
                if (m_act[i]) cnt[m_own[i]]++;
            fidx = -1;
            for (int i = 0; i < NS; i++)
                if (!m_act[i] && fidx < 0) fidx = i;
            for (int t = 0; t < 2; t++) begin
                elig[t] = m_pend[t] && cnt[t] < MAXT && fidx >= 0;
                acc[t]  = fire_req[t] && !m_prev[t]
                          && (E - 1 - m_lg[t]) >= CDN
                          && cnt[t] < MAXT && !m_pend[t];
            end
            gnt = elig[0] || elig[1];
            gt  = (elig[0] && elig[1]) ? int'(m_rr) : (elig[1] ? 1 : 0);
            for (int i = 0; i < NS; i++)
                ret[i] = m_act[i] && (slot_kill[i] || E == m_exp[i]);
            for (int i = 0; i < NS; i++)
                if (ret[i]) m_act[i] = 0;
            for (int t = 0; t < 2; t++)
                if (acc[t]) m_pend[t] = 1;
            if (gnt) begin
                m_act[fidx] = 1;
                m_own[fidx] = (gt == 1);
                m_exp[fidx] = E + LIFE;
                m_lg[gt]    = E;
                m_pend[gt]  = 0;
                l.e     = E;
                l.slot  = fidx;
                l.owner = gt;
                lq.push_back(l);
            end
            if (elig[0] && elig[1]) m_rr = ~m_rr;
            m_prev = fire_req;
        end
        cnt[0] = 0;
        cnt[1] = 0;
        s.e = E;
        for (int i = 0; i < NS; i++) begin
            s.act[i] = m_act[i];
            s.own[i] = m_own[i];
            if (m_act[i]) cnt[m_own[i]]++;
        end
        s.cnt = {3'(cnt[1]), 3'(cnt[0])};
        sq.push_back(s);
        E++;
    endtask

    task automatic step(bit [1:0] r, bit [3:0] k, bit rst, int n);
        repeat (n) begin
            @(negedge frame_clk);
            fire_req  = r;
            slot_kill = k;
            Reset     = rst;
            model_step();
        end
    endtask

    // Monitor: compare registered outputs once per cycle after the edge.
    initial begin
        st_t s;
        ln_t l;
        bit  exp_lv;
        forever begin
            @(posedge frame_clk);
            #1;
            if (sq.size() > 0) begin
                s = sq.pop_front();
                chk("slot_active", int'(slot_active), int'(s.act));
                chk("slot_owner", int'(slot_owner & s.act),
                    int'(s.own & s.act));
                chk("tank_count", int'(tank_count), int'(s.cnt));
                while (lq.size() > 0 && lq[0].e < s.e) begin
                    l = lq.pop_front();
                    chk("launch_lost", 0, 1);
                end
                exp_lv = lq.size() > 0 && lq[0].e == s.e;
                chk("launch_valid", int'(launch_valid), int'(exp_lv));
                if (exp_lv) begin
                    l = lq.pop_front();
                    if (launch_valid) begin
                        chk("launch_slot", int'(launch_slot), l.slot);
                        chk("launch_owner", int'(launch_owner), l.owner);
                    end
                end
            end
        end
    end

    initial begin
        bit [1:0] r;
        bit [3:0] k;
        bit       rst;
        step(2'b00, 4'h0, 1'b1, 3);
        step(2'b01, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 5);
        step(2'b01, 4'h0, 1'b0, 40);
        step(2'b00, 4'h0, 1'b0, 1);
        step(2'b01, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 3);
        step(2'b00, 4'h0, 1'b1, 2);
        step(2'b11, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 20);
        step(2'b11, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 5);
        step(2'b00, 4'h0, 1'b1, 2);
        for (int j = 0; j < 3; j++) begin
            step(2'b01, 4'h0, 1'b0, 1);
            step(2'b00, 4'h0, 1'b0, 19);
        end
        step(2'b00, 4'h1, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 20);
        step(2'b01, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 3);
        step(2'b00, 4'h0, 1'b1, 2);
        step(2'b11, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 20);
        step(2'b11, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b0, 320);
        step(2'b01, 4'h0, 1'b0, 1);
        step(2'b00, 4'h0, 1'b1, 1);
        step(2'b00, 4'h0, 1'b0, 3);
        r = 2'b00;
        for (int c = 0; c < 4000; c++) begin
            for (int t = 0; t < 2; t++)
                if ($urandom_range(0, 5) == 0) r[t] = ~r[t];
            k = 4'h0;
            if ($urandom_range(0, 30) == 0)
                k[$urandom_range(0, 3)] = 1'b1;
            rst = ($urandom_range(0, 1499) == 0);
            step(r, k, rst, 1);
        end
        step(2'b00, 4'h0, 1'b0, 3);
        @(posedge frame_clk);
        #2;
        chk("launch_drain", lq.size(), 0);
        chk("state_drain", sq.size(), 0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
